instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Encodes field-level instruction requests into the 9-bit instruction format consumed by the control decoder.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from address 0.
- Sits between the test/boot loader and instruction memory; signals program completion on a done-branch.
- Flags illegal fields and memory overflow.

Parameters:
- ADDR_W, 8, instruction memory address width; capacity is 2**ADDR_W words.
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears address/count/error and enters LOAD
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- instr_type  in  2  00=R, 01=I, 10=Mem, 11=Branch
- alu_func  in  3  R-type function
- src_reg1  in  2  source reg 1 (R/Mem use bit0 only; Branch uses both bits)
- src_reg2  in  2  source reg 2
- dest_reg  in  2  destination reg (R, I)
- immediate  in  5  I-type immediate
- mem_load  in  1  Mem-type: 1=load, 0=store
- mem_addr  in  5  Mem-type address
- done_flag  in  1  Branch-type done
- branch_reg  in  2  Branch-type jump-address reg
- im_we  out  1  instruction memory write request
- im_ready  in  1  memory accepts write this cycle
- im_addr  out  ADDR_W  write address
- im_wdata  out  9  encoded instruction
- prog_done  out  1  program fully written
- prog_len  out  ADDR_W+1  number of words written
- err  out  1  sticky error
- err_code  out  2  00 none, 01 illegal field, 10 overflow

Behaviour:
- Reset: state IDLE; FIFO empty; in_ready=0, im_we=0, im_addr=0, im_wdata=0, prog_done=0, prog_len=0, err=0, err_code=00.
- Encoding:
  - R: {00, alu_func, src_reg1[0], src_reg2[0], dest_reg}.
  - I: {01, dest_reg, immediate}.
  - Mem: {10, mem_load, src_reg1[0], mem_addr}.
  - Branch: {11, done_flag, src_reg1, src_reg2, branch_reg}.
  - Fields unused by a type are ignored.
- Illegal field: src_reg1[1] or src_reg2[1] set on R-type, or src_reg1[1] set on Mem-type.
- FSM states:
  - IDLE: in_ready=0; start → LOAD.
  - LOAD: in_ready = !fifo_full && (accepted count < 2**ADDR_W).
    - A transfer occurs when in_valid && in_ready.
    - Legal transfer: the word is pushed into the FIFO at that edge and the count increments.
    - Illegal transfer: the word is dropped; err=1, err_code=01; → ERROR.
    - Legal Branch with done_flag=1: word is pushed; → FINISHED.
    - in_valid while count == 2**ADDR_W: err=1, err_code=10; → ERROR.
  - FINISHED: in_ready=0; when FIFO is empty, prog_done=1 and holds until start or reset.
  - ERROR: in_ready=0; FIFO still drains; err/err_code hold until start or reset.
  - start in any state: count, im_addr, prog_len, err and prog_done are cleared, FIFO is flushed (pending words discarded), → LOAD. start takes priority over a same-cycle transfer, which is ignored.
- Memory side:
  - im_we = FIFO non-empty; im_wdata = FIFO head; im_addr = write pointer.
  - A write completes on im_we && im_ready: FIFO pops, im_addr increments, prog_len increments.
  - im_we/im_wdata/im_addr hold stable while im_ready=0.
- Latency: a request accepted at edge N (empty FIFO) gives im_we=1 with its word in cycle N+1.
- FIFO:
  - Push and pop in the same cycle are allowed when not full; occupancy is unchanged.
  - A full FIFO deasserts in_ready; there is no pass-through.
- Ordering: words are written strictly in acceptance order; addresses are contiguous from 0 with no wrap.
- Reset mid-operation: all state is discarded immediately and im_we=0 next cycle.

Test Plan:
1. start, R func=010 src1=01 src2=00 dest=10 → im_wdata=9'h02A at im_addr=0, im_we in the cycle after acceptance.
2. I dest=11 imm=17, then Mem load=1 src1=01 addr=5, then Branch done=1 src1=00 src2=01 br=10 → writes 9'h0F1@0, 9'h165@1, 9'h1C6@2; then prog_done=1, prog_len=3, in_ready=0.
3. im_ready held 0 for 10 cycles during a burst of 6 requests → in_ready drops after 4 accepts; outputs stay stable; after im_ready=1 all 6 words are written in order at addresses 0–5.
4. R-type with src_reg1=10 after two legal words → the illegal word is not written; err=1, err_code=01; the two legal words still drain to addresses 0–1; in_ready=0 until start.
5. ADDR_W=2: 4 non-done words accepted, then in_valid → in_ready=0, err_code=10, prog_len=4 after drain.
6. reset asserted while FIFO holds 3 words → next cycle im_we=0, im_addr=0, all outputs at reset values; start restarts writing at address 0.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes field-level instruction requests into 9-bit words,
//               buffers them and writes them into instruction memory from 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        instr_type,
  input  logic [2:0]        alu_func,
  input  logic [1:0]        src_reg1,
  input  logic [1:0]        src_reg2,
  input  logic [1:0]        dest_reg,
  input  logic [4:0]        immediate,
  input  logic              mem_load,
  input  logic [4:0]        mem_addr,
  input  logic              done_flag,
  input  logic [1:0]        branch_reg,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [8:0]        im_wdata,
  output logic              prog_done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int            PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] C_CAP    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [1:0]    C_ERR_ILL  = 2'b01;
  localparam logic [1:0]    C_ERR_OVF  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_LOAD     = 2'b01,
    S_FINISHED = 2'b10,
    S_ERROR    = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [8:0]         r_fifo [FIFO_DEPTH];
  logic [PTR_W:0]     r_wptr;
  logic [PTR_W:0]     r_rptr;
  logic [ADDR_W:0]    r_count;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W:0]    r_plen;
  logic               r_err;
  logic [1:0]         r_err_code;

  logic [8:0]         w_word;
  logic               w_illegal;
  logic               w_is_done;
  logic               w_empty;
  logic               w_full;
  logic               w_in_ready;
  logic               w_xfer;
  logic               w_push;
  logic               w_pop;
  logic               w_set_err;
  logic [1:0]         w_err_code_nxt;

  always_comb begin
    w_word    = '0;
    w_illegal = 1'b0;
    w_is_done = 1'b0;
    case (instr_type)
      2'b00: begin
        w_word    = {2'b00, alu_func, src_reg1[0], src_reg2[0], dest_reg};
        w_illegal = src_reg1[1] | src_reg2[1];
      end
      2'b01: w_word = {2'b01, dest_reg, immediate};
      2'b10: begin
        w_word    = {2'b10, mem_load, src_reg1[0], mem_addr};
        w_illegal = src_reg1[1];
      end
      default: begin
        w_word    = {2'b11, done_flag, src_reg1, src_reg2, branch_reg};
        w_is_done = done_flag;
      end
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);

  assign w_in_ready = (r_state == S_LOAD) && !w_full && (r_count < C_CAP);
  assign w_xfer     = in_valid && w_in_ready;
  assign w_push     = w_xfer && !w_illegal && !start;
  assign w_pop      = !w_empty && im_ready && !start;

  always_comb begin
    w_state_nxt    = r_state;
    w_set_err      = 1'b0;
    w_err_code_nxt = r_err_code;
    if (start) begin
      w_state_nxt = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            if (w_illegal) begin
              w_state_nxt    = S_ERROR;
              w_set_err      = 1'b1;
              w_err_code_nxt = C_ERR_ILL;
            end else if (w_is_done) begin
              w_state_nxt = S_FINISHED;
            end
          end else if (in_valid && (r_count == C_CAP)) begin
            w_state_nxt    = S_ERROR;
            w_set_err      = 1'b1;
            w_err_code_nxt = C_ERR_OVF;
          end
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_addr     <= '0;
      r_plen     <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_addr     <= '0;
        r_plen     <= '0;
        r_err      <= 1'b0;
        r_err_code <= 2'b00;
      end else begin
        if (w_push) begin
          r_wptr  <= r_wptr + (PTR_W+1)'(1);
          r_count <= r_count + (ADDR_W+1)'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + (PTR_W+1)'(1);
          r_addr <= r_addr + ADDR_W'(1);
          r_plen <= r_plen + (ADDR_W+1)'(1);
        end
        if (w_set_err) begin
          r_err      <= 1'b1;
          r_err_code <= w_err_code_nxt;
        end
      end
    end
  end

  // Storage needs no reset: the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr[PTR_W-1:0]] <= w_word;
    end
  end

  assign in_ready  = w_in_ready;
  assign im_we     = !w_empty;
  assign im_wdata  = w_empty ? 9'd0 : r_fifo[r_rptr[PTR_W-1:0]];
  assign im_addr   = r_addr;
  assign prog_done = (r_state == S_FINISHED) && w_empty;
  assign prog_len  = r_plen;
  assign err       = r_err;
  assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed, table-driven bench for instr_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  typedef struct {
    logic [1:0] typ;
    logic [2:0] func;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] d;
    logic [4:0] imm;
    logic       ld;
    logic [4:0] maddr;
    logic       done;
    logic [1:0] br;
  } req_t;

  typedef struct {
    req_t       r;
    logic [8:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] instr_type = '0;
  logic [2:0] alu_func = '0;
  logic [1:0] src_reg1 = '0;
  logic [1:0] src_reg2 = '0;
  logic [1:0] dest_reg = '0;
  logic [4:0] immediate = '0;
  logic       mem_load = 1'b0;
  logic [4:0] mem_addr = '0;
  logic       done_flag = 1'b0;
  logic [1:0] branch_reg = '0;
  logic       im_we;
  logic       im_ready = 1'b1;
  logic [7:0] im_addr;
  logic [8:0] im_wdata;
  logic       prog_done;
  logic [8:0] prog_len;
  logic       err;
  logic [1:0] err_code;

  logic       reset2 = 1'b1;
  logic       start2 = 1'b0;
  logic       in_valid2 = 1'b0;
  logic       in_ready2;
  logic       im_we2;
  logic       im_ready2 = 1'b1;
  logic [1:0] im_addr2;
  logic [8:0] im_wdata2;
  logic       prog_done2;
  logic [2:0] prog_len2;
  logic       err2;
  logic [1:0] err_code2;

  int total = 0;
  int bad = 0;
  int qa[$];
  int qd[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .instr_type(instr_type), .alu_func(alu_func),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .dest_reg(dest_reg),
    .immediate(immediate), .mem_load(mem_load), .mem_addr(mem_addr),
    .done_flag(done_flag), .branch_reg(branch_reg), .im_we(im_we),
    .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .prog_done(prog_done), .prog_len(prog_len), .err(err), .err_code(err_code)
  );

  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .reset(reset2), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .instr_type(instr_type), .alu_func(alu_func),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .dest_reg(dest_reg),
    .immediate(immediate), .mem_load(mem_load), .mem_addr(mem_addr),
    .done_flag(done_flag), .branch_reg(branch_reg), .im_we(im_we2),
    .im_ready(im_ready2), .im_addr(im_addr2), .im_wdata(im_wdata2),
    .prog_done(prog_done2), .prog_len(prog_len2), .err(err2), .err_code(err_code2)
  );

  always @(posedge clk) begin
    if (!reset && !start && im_we && im_ready) begin
      qa.push_back(int'(im_addr));
      qd.push_back(int'(im_wdata));
    end
  end

  function automatic req_t mk(input logic [1:0] t, input logic [2:0] f,
                              input logic [1:0] s1, input logic [1:0] s2,
                              input logic [1:0] d, input logic [4:0] imm,
                              input logic ld, input logic [4:0] ma,
                              input logic dn, input logic [1:0] br);
    req_t r;
    r.typ = t; r.func = f; r.s1 = s1; r.s2 = s2; r.d = d;
    r.imm = imm; r.ld = ld; r.maddr = ma; r.done = dn; r.br = br;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input req_t r);
    instr_type = r.typ; alu_func = r.func; src_reg1 = r.s1; src_reg2 = r.s2;
    dest_reg = r.d; immediate = r.imm; mem_load = r.ld; mem_addr = r.maddr;
    done_flag = r.done; branch_reg = r.br;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    qa.delete();
    qd.delete();
  endtask

  // Holds the request until the encoder is ready, then returns just after the accepting edge.
  task automatic send(input req_t r);
    int n;
    apply(r);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{mk(2'd0, 3'b010, 2'b01, 2'b00, 2'b10, 5'd0,  1'b0, 5'd0,  1'b0, 2'b00), 9'h02A};
    vecs[1] = '{mk(2'd0, 3'b111, 2'b00, 2'b01, 2'b01, 5'd31, 1'b1, 5'd31, 1'b1, 2'b11), 9'h075};
    vecs[2] = '{mk(2'd1, 3'b111, 2'b11, 2'b11, 2'b11, 5'd17, 1'b1, 5'd9,  1'b1, 2'b11), 9'h0F1};
    vecs[3] = '{mk(2'd1, 3'b000, 2'b00, 2'b00, 2'b00, 5'd0,  1'b0, 5'd0,  1'b0, 2'b00), 9'h080};
    vecs[4] = '{mk(2'd2, 3'b101, 2'b01, 2'b11, 2'b10, 5'd3,  1'b1, 5'd5,  1'b1, 2'b01), 9'h165};
    vecs[5] = '{mk(2'd2, 3'b000, 2'b00, 2'b00, 2'b00, 5'd0,  1'b0, 5'd31, 1'b0, 2'b00), 9'h11F};
    vecs[6] = '{mk(2'd3, 3'b111, 2'b11, 2'b10, 2'b11, 5'd31, 1'b1, 5'd31, 1'b0, 2'b01), 9'h1B9};

    // Reset state
    tick();
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    #2;
    chk("rst_in_ready_idle", {31'd0, in_ready}, 32'd0);
    chk("rst_outputs", {im_we, im_addr, im_wdata, prog_done, prog_len, err, err_code},
        32'd0);
    in_valid = 1'b0;
    tick();

    // Encoding table, one word at a time with im_ready high
    im_ready = 1'b1;
    do_start();
    chk("t1_no_we_before_accept", {31'd0, im_we}, 32'd0);
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].r);
      chk($sformatf("vec%0d_we", i), {31'd0, im_we}, 32'd1);
      chk($sformatf("vec%0d_wdata", i), {23'd0, im_wdata}, {23'd0, vecs[i].exp});
      chk($sformatf("vec%0d_addr", i), {24'd0, im_addr}, i);
    end

    // Short program ending on a done-branch
    do_start();
    send(mk(2'd1, 3'b000, 2'b00, 2'b00, 2'b11, 5'd17, 1'b0, 5'd0, 1'b0, 2'b00));
    send(mk(2'd2, 3'b000, 2'b01, 2'b00, 2'b00, 5'd0,  1'b1, 5'd5, 1'b0, 2'b00));
    send(mk(2'd3, 3'b000, 2'b00, 2'b01, 2'b00, 5'd0,  1'b0, 5'd0, 1'b1, 2'b10));
    for (int k = 0; k < 4; k++) tick();
    chk("t2_prog_done", {31'd0, prog_done}, 32'd1);
    chk("t2_prog_len", {23'd0, prog_len}, 32'd3);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_nwrites", qd.size(), 32'd3);
    if (qd.size() == 3) begin
      chk("t2_w0", {qa[0][7:0], qd[0][8:0]}, {8'd0, 9'h0F1});
      chk("t2_w1", {qa[1][7:0], qd[1][8:0]}, {8'd1, 9'h165});
      chk("t2_w2", {qa[2][7:0], qd[2][8:0]}, {8'd2, 9'h1C6});
    end

    // Back-pressure: memory stalls while six requests arrive
    im_ready = 1'b0;
    do_start();
    for (int k = 0; k < 4; k++) send(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'(k), 1'b0, 5'd0, 1'b0, 2'd0));
    apply(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'd4, 1'b0, 5'd0, 1'b0, 2'd0));
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t3_hold%0d", k), {in_ready, im_we, im_addr, im_wdata},
          {1'b0, 1'b1, 8'd0, 9'h0A0});
      tick();
    end
    im_ready = 1'b1;
    send(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'd4, 1'b0, 5'd0, 1'b0, 2'd0));
    send(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'd5, 1'b0, 5'd0, 1'b0, 2'd0));
    for (int k = 0; k < 8; k++) tick();
    chk("t3_nwrites", qd.size(), 32'd6);
    for (int k = 0; k < qd.size() && k < 6; k++) begin
      chk($sformatf("t3_w%0d", k), {qa[k][7:0], qd[k][8:0]}, {8'(k), 9'h0A0 + 9'(k)});
    end
    chk("t3_prog_len", {23'd0, prog_len}, 32'd6);

    // Illegal field after two legal words
    do_start();
    send(mk(2'd0, 3'b010, 2'b01, 2'b00, 2'b10, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0));
    send(mk(2'd1, 3'b000, 2'b00, 2'b00, 2'b11, 5'd17, 1'b0, 5'd0, 1'b0, 2'd0));
    send(mk(2'd0, 3'b010, 2'b10, 2'b00, 2'b10, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0));
    chk("t4_err", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});
    chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
    apply(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'd0, 5'd1, 1'b0, 5'd0, 1'b0, 2'd0));
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    in_valid = 1'b0;
    chk("t4_in_ready_hold", {31'd0, in_ready}, 32'd0);
    chk("t4_err_hold", {29'd0, err, err_code}, {29'd0, 1'b1, 2'b01});
    chk("t4_nwrites", qd.size(), 32'd2);
    if (qd.size() == 2) begin
      chk("t4_w0", {qa[0][7:0], qd[0][8:0]}, {8'd0, 9'h02A});
      chk("t4_w1", {qa[1][7:0], qd[1][8:0]}, {8'd1, 9'h0F1});
    end
    chk("t4_prog_len", {23'd0, prog_len}, 32'd2);

    // Reset while three words are buffered
    im_ready = 1'b0;
    do_start();
    for (int k = 0; k < 3; k++) send(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'(k), 1'b0, 5'd0, 1'b0, 2'd0));
    chk("t6_buffered", {31'd0, im_we}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_reset_outputs", {in_ready, im_we, im_addr, im_wdata, prog_done, prog_len, err, err_code},
        32'd0);
    im_ready = 1'b1;
    do_start();
    send(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'd3, 1'b0, 5'd0, 1'b0, 2'd0));
    chk("t6_restart", {im_we, im_addr, im_wdata}, {1'b1, 8'd0, 9'h0A3});

    // Overflow on a 4-word memory
    apply(mk(2'd1, 3'd0, 2'd0, 2'd0, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0));
    reset2 = 1'b0;
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    in_valid2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t5_in_ready%0d", k), {31'd0, in_ready2}, (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid2 = 1'b0;
    chk("t5_err", {29'd0, err2, err_code2}, {29'd0, 1'b1, 2'b10});
    for (int k = 0; k < 4; k++) tick();
    chk("t5_prog_len", {29'd0, prog_len2}, 32'd4);
    chk("t5_drained", {31'd0, im_we2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
